demux_dispatch: RTL and testbench

//  Upstream feeder for the 4-way N-bit demux. Accepts a valid/ready word

---
 rtl/demux_dispatch.sv | 157 +++++++++++++++
 tb/tb_demux_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : demux_dispatch
//  Purpose  : Upstream feeder for a 4-way N-bit demux. Accepts a valid/ready
//             word stream into a DEPTH-entry FIFO and presents the head word
//             on the demux data/select inputs together with a one-hot
//             per-channel valid. The destination channel comes from the input
//             (mode=0, addressed) or from a round-robin pointer assigned at
//             push time (mode=1).
//  Ports    : clk, rst_n          clock, async active-low reset
//             in_data_i/in_dest_i word and target channel (addressed mode)
//             in_valid_i/in_ready_o  input handshake
//             mode_i              0 = addressed, 1 = round-robin
//             out_a_o/out_s_o     head word / head channel
//             out_valid_o         one-hot valid, bit k = channel k
//             out_ready_i         per-channel consumer ready
//             level_o             FIFO occupancy
//             ch_count_o          (DISPATCH_STATS_EN only) 4 x 16-bit
//                                 saturating per-channel pop counters
//  Options  : DISPATCH_STATS_EN   adds ch_count_o and its counters
//  Revision : 1.0  initial release
// ============================================================================
module demux_dispatch #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               in_data_i,
    input  logic [1:0]                 in_dest_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       mode_i,
    output logic [N-1:0]               out_a_o,
    output logic [1:0]                 out_s_o,
    output logic [3:0]                 out_valid_o,
    input  logic [3:0]                 out_ready_i,
`ifdef DISPATCH_STATS_EN
    output logic [63:0]                ch_count_o,
`endif
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    // Storage (no reset needed: head outputs are masked while EMPTY)
    logic [N-1:0]  mem_data_q [DEPTH];
    logic [1:0]    mem_dest_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [1:0]    rr_q,     rr_d;

    state_t        state_w;
    logic          push_w;
    logic          pop_w;
    logic [1:0]    dest_w;

    // State is a pure decode of occupancy; there is no separate state register.
    always_comb begin
        state_w = ST_ACTIVE;
        if (level_q == '0) begin
            state_w = ST_EMPTY;
        end else if (level_q == C_FULL_LEVEL) begin
            state_w = ST_FULL;
        end
    end

    // in_ready depends only on registered occupancy, never on the same-cycle
    // pop, so no combinational path runs from out_ready_i to in_ready_o.
    assign in_ready_o = (state_w != ST_FULL);
    assign push_w     = in_valid_i & in_ready_o;
    assign dest_w     = mode_i ? rr_q : in_dest_i;

    always_comb begin
        out_a_o     = '0;
        out_s_o     = 2'd0;
        out_valid_o = 4'b0000;
        if (state_w != ST_EMPTY) begin
            out_a_o     = mem_data_q[rd_ptr_q];
            out_s_o     = mem_dest_q[rd_ptr_q];
            out_valid_o = 4'b0001 << out_s_o;
        end
    end

    // Only the head's own channel ready matters: head-of-line blocking.
    assign pop_w   = (state_w != ST_EMPTY) & out_ready_i[out_s_o];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rr_d     = rr_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (mode_i) begin
                rr_d = rr_q + 2'd1;
            end
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_w, pop_w})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_q     <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rr_q     <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_data_q[wr_ptr_q] <= in_data_i;
            mem_dest_q[wr_ptr_q] <= dest_w;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] cnt_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_stats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[k] <= 16'h0000;
            end else if (pop_w && (out_s_o == 2'(k)) && (cnt_q[k] != 16'hFFFF)) begin
                cnt_q[k] <= cnt_q[k] + 16'h0001;
            end
        end
        assign ch_count_o[16*k +: 16] = cnt_q[k];
    end : g_stats
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_dispatch
//  Purpose  : Self-checking bench for demux_dispatch. A scoreboard queue
//             receives {data,dest} at every accepted push; a negedge monitor
//             pops and compares it whenever the head is transferred.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_dispatch;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  in_data_i = '0;
    logic [1:0]    in_dest_i = 2'd0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic          mode_i = 1'b0;
    logic [N-1:0]  out_a_o;
    logic [1:0]    out_s_o;
    logic [3:0]    out_valid_o;
    logic [3:0]    out_ready_i = 4'b0000;
    logic [LW-1:0] level_o;
`ifdef DISPATCH_STATS_EN
    logic [63:0]   ch_count_o;
`endif

    demux_dispatch #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data_i),
        .in_dest_i   (in_dest_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .out_a_o     (out_a_o),
        .out_s_o     (out_s_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
`ifdef DISPATCH_STATS_EN
        .ch_count_o  (ch_count_o),
`endif
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [N+1:0] sb_q[$];   // {data, dest}
    logic [1:0]   rr_model = 2'd0;
    bit           mon_en = 1'b0;

    // Transfer monitor: a pop happens at the next posedge when the head's
    // channel is ready; compare the head against the scoreboard then.
    always @(negedge clk) begin
        if (mon_en && rst_n && (out_valid_o != 4'b0000)) begin
            checks++;
            if (out_valid_o !== (4'b0001 << out_s_o)) begin
                errors++;
                $display("FAIL onehot: out_valid=%b out_s=%0d", out_valid_o, out_s_o);
            end
            if ((out_valid_o & out_ready_i) != 4'b0000) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got a=%h s=%0d, scoreboard empty", out_a_o, out_s_o);
                end else begin
                    logic [N+1:0] exp;
                    exp = sb_q.pop_front();
                    if ({out_a_o, out_s_o} !== exp) begin
                        errors++;
                        $display("FAIL pop_data: got a=%h s=%0d, expected a=%h s=%0d",
                                 out_a_o, out_s_o, exp[N+1:2], exp[1:0]);
                    end
                end
            end
        end
    end

    // Drive one word at posedge+1 and hold it until accepted (bounded).
    task automatic push_word(input logic [N-1:0] d, input logic [1:0] dst, input logic m);
        bit done = 1'b0;
        in_data_i  = d;
        in_dest_i  = dst;
        mode_i     = m;
        in_valid_i = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready_o) begin
                sb_q.push_back({d, (m ? rr_model : dst)});
                if (m) rr_model = rr_model + 2'd1;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: word %h not accepted in 20 cycles", d);
        end
    endtask

    task automatic wait_empty(input int max_cycles);
        int c = 0;
        while (level_o != '0 && c < max_cycles) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (level_o !== '0) begin
            errors++;
            $display("FAIL drain_timeout: level=%0d, expected 0", level_o);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid_o !== 4'b0000 || level_o !== '0 || in_ready_o !== 1'b1 ||
            out_a_o !== '0 || out_s_o !== 2'd0) begin
            errors++;
            $display("FAIL %s: valid=%b level=%0d ready=%b a=%h s=%0d, expected 0000/0/1/00/0",
                     tag, out_valid_o, level_o, in_ready_o, out_a_o, out_s_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle("reset_asserted");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_released_idle");
    endtask

    task automatic test_addressed();
        out_ready_i = 4'b0000;
        push_word(8'hD5, 2'd2, 1'b0);
        checks++;
        if (out_a_o !== 8'hD5 || out_s_o !== 2'd2 || out_valid_o !== 4'b0100 || level_o !== 3'd1) begin
            errors++;
            $display("FAIL addr_head: a=%h s=%0d valid=%b level=%0d, expected D5/2/0100/1",
                     out_a_o, out_s_o, out_valid_o, level_o);
        end
        // Ready on other channels must not pop the head
        out_ready_i = 4'b1011;
        @(posedge clk); #1;
        checks++;
        if (level_o !== 3'd1 || out_a_o !== 8'hD5) begin
            errors++;
            $display("FAIL addr_other_ready: level=%0d a=%h, expected 1/D5", level_o, out_a_o);
        end
        out_ready_i = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (level_o !== 3'd0 || out_valid_o !== 4'b0000) begin
            errors++;
            $display("FAIL addr_pop: level=%0d valid=%b, expected 0/0000", level_o, out_valid_o);
        end
        out_ready_i = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] words [5] = '{8'hAA, 8'hF0, 8'h11, 8'h22, 8'h33};
        out_ready_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push_word(words[i], 2'd3, 1'b1);
            checks++;
            if (level_o !== 3'd1) begin
                errors++;
                $display("FAIL rr_throughput: after push %0d level=%0d, expected 1", i, level_o);
            end
        end
        wait_empty(10);
        out_ready_i = 4'b0000;
    endtask

    task automatic test_full_backpressure();
        out_ready_i = 4'b0000;
        push_word(8'h01, 2'd1, 1'b0);
        push_word(8'h02, 2'd2, 1'b0);
        push_word(8'h03, 2'd3, 1'b0);
        push_word(8'h04, 2'd0, 1'b0);
        checks++;
        if (level_o !== 3'd4 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ready=%b, expected 4/0", level_o, in_ready_o);
        end
        // Fifth word held by source while full
        in_data_i = 8'h05; in_dest_i = 2'd1; mode_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (level_o !== 3'd4 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: level=%0d ready=%b, expected 4/0", level_o, in_ready_o);
        end
        // Pop the head (dest 1); no push may happen on the same edge
        out_ready_i = 4'b0010;
        @(posedge clk); #1;
        out_ready_i = 4'b0000;
        checks++;
        if (level_o !== 3'd3 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_no_push: level=%0d ready=%b, expected 3/1", level_o, in_ready_o);
        end
        @(negedge clk);
        if (in_ready_o) sb_q.push_back({8'h05, 2'd1});
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd4) begin
            errors++;
            $display("FAIL full_fifth_accept: level=%0d, expected 4", level_o);
        end
        out_ready_i = 4'b1111;
        wait_empty(10);
        out_ready_i = 4'b0000;
    endtask

    task automatic test_head_of_line();
        out_ready_i = 4'b0001;
        push_word(8'h3C, 2'd3, 1'b0);
        push_word(8'hC3, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (level_o !== 3'd2 || out_s_o !== 2'd3 || out_valid_o !== 4'b1000 || out_a_o !== 8'h3C) begin
            errors++;
            $display("FAIL hol_blocked: level=%0d s=%0d valid=%b a=%h, expected 2/3/1000/3C",
                     level_o, out_s_o, out_valid_o, out_a_o);
        end
        out_ready_i = 4'b1000;
        @(posedge clk); #1;
        checks++;
        if (level_o !== 3'd1 || out_s_o !== 2'd0 || out_valid_o !== 4'b0001 || out_a_o !== 8'hC3) begin
            errors++;
            $display("FAIL hol_next: level=%0d s=%0d valid=%b a=%h, expected 1/0/0001/C3",
                     level_o, out_s_o, out_valid_o, out_a_o);
        end
        out_ready_i = 4'b0001;
        wait_empty(5);
        out_ready_i = 4'b0000;
    endtask

    task automatic test_reset_mid_stream();
        out_ready_i = 4'b0000;
        push_word(8'h71, 2'd0, 1'b1);
        push_word(8'h72, 2'd2, 1'b0);
        push_word(8'h73, 2'd1, 1'b1);
        checks++;
        if (level_o !== 3'd3) begin
            errors++;
            $display("FAIL mid_level: level=%0d, expected 3", level_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset_async");
        sb_q.delete();
        rr_model = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // rr pointer must have returned to 0
        out_ready_i = 4'b1111;
        push_word(8'h99, 2'd3, 1'b1);
        checks++;
        if (out_s_o !== 2'd0 || out_a_o !== 8'h99) begin
            errors++;
            $display("FAIL mid_rr_reset: s=%0d a=%h, expected 0/99", out_s_o, out_a_o);
        end
        wait_empty(5);
        out_ready_i = 4'b0000;
    endtask

`ifdef DISPATCH_STATS_EN
    task automatic test_stats_saturate();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        rr_model = 2'd0;
        checks++;
        if (ch_count_o !== 64'd0) begin
            errors++;
            $display("FAIL stats_reset: ch_count=%h, expected 0", ch_count_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready_i = 4'b0010;
        mode_i = 1'b0;
        in_dest_i = 2'd1;
        in_valid_i = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data_i = N'(i);
            @(negedge clk);
            if (in_ready_o) sb_q.push_back({N'(i), 2'd1});
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        wait_empty(5);
        checks++;
        if (ch_count_o[31:16] !== 16'hFFFF || ch_count_o[15:0] !== 16'h0 ||
            ch_count_o[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL stats_saturate: ch_count=%h, expected 00000000FFFF0000", ch_count_o);
        end
        out_ready_i = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_addressed();
        test_round_robin();
        test_full_backpressure();
        test_head_of_line();
        test_reset_mid_stream();
`ifdef DISPATCH_STATS_EN
        test_stats_saturate();
`endif
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
